// File: rtl/axis_flit_serializer.sv
// AXI-Stream beat to router flit serializer with credit-based flow control.
// Optional macro AXIS_FLIT_SERIALIZER_CREDIT_CHECK_EN enables the sticky credit overflow flag.
module axis_flit_serializer #(
    parameter int TDEST_WIDTH          = 6,
    parameter int TDATA_WIDTH          = 512,
    parameter int TUSER_WIDTH          = 32,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4,
    localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axis_tvalid,
    output logic                   axis_tready,
    input  logic [TDATA_WIDTH-1:0] axis_tdata,
    input  logic                   axis_tlast,
    input  logic [TUSER_WIDTH-1:0] axis_tuser,
    input  logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [TDEST_WIDTH-1:0] dest_out,
    output logic [TUSER_WIDTH-1:0] user_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    output logic                   credit_err
);

    localparam int IDX_WIDTH    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_WIDTH-1:0]    idx_r, idx_s;
    logic [CREDIT_WIDTH-1:0] credits_r, credits_s;
    logic [TDATA_WIDTH-1:0]  data_r;
    logic [TDEST_WIDTH-1:0]  dest_r;
    logic [TUSER_WIDTH-1:0]  user_r;
    logic                    last_r;

    logic busy_s;
    logic last_flit_s;
    logic send_s;
    logic tready_s;
    logic xfer_s;
    logic [FLIT_WIDTH-1:0] flit_s;

    assign busy_s      = (state_r == BUSY);
    assign last_flit_s = (idx_r == LAST_IDX);
    assign xfer_s      = axis_tvalid & tready_s;
    assign flit_s      = data_r[int'(idx_r) * FLIT_WIDTH +: FLIT_WIDTH];

    // Handshake: a new beat is taken while idle or as the last flit of the held beat leaves.
    always_comb begin
        send_s   = 1'b0;
        tready_s = 1'b0;
        if (rst_n) begin
            send_s   = busy_s & (credits_r != {CREDIT_WIDTH{1'b0}});
            tready_s = ~busy_s | (send_s & last_flit_s);
        end else begin
            send_s   = 1'b0;
            tready_s = 1'b0;
        end
    end

    // Next-state and flit index.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_s = BUSY;
                    idx_s   = {IDX_WIDTH{1'b0}};
                end else begin
                    state_s = IDLE;
                    idx_s   = idx_r;
                end
            end
            BUSY: begin
                if (send_s & last_flit_s) begin
                    state_s = xfer_s ? BUSY : IDLE;
                    idx_s   = {IDX_WIDTH{1'b0}};
                end else if (send_s) begin
                    state_s = BUSY;
                    idx_s   = idx_r + IDX_WIDTH'(1);
                end else begin
                    state_s = BUSY;
                    idx_s   = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IDX_WIDTH{1'b0}};
            end
        endcase
    end

    // Credit counter; a simultaneous send and return cancel, returns saturate at the buffer depth.
    always_comb begin
        credits_s = credits_r;
        case ({send_s, credit_in})
            2'b10: credits_s = credits_r - CREDIT_WIDTH'(1);
            2'b01: begin
                if (credits_r != MAX_CREDITS) begin
                    credits_s = credits_r + CREDIT_WIDTH'(1);
                end else begin
                    credits_s = credits_r;
                end
            end
            default: credits_s = credits_r;
        endcase
    end

    // State, credits and the held beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_WIDTH{1'b0}};
            credits_r <= MAX_CREDITS;
            data_r    <= {TDATA_WIDTH{1'b0}};
            dest_r    <= {TDEST_WIDTH{1'b0}};
            user_r    <= {TUSER_WIDTH{1'b0}};
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            credits_r <= credits_s;
            if (xfer_s) begin
                data_r <= axis_tdata;
                dest_r <= axis_tdest;
                user_r <= axis_tuser;
                last_r <= axis_tlast;
            end
        end
    end

`ifdef AXIS_FLIT_SERIALIZER_CREDIT_CHECK_EN
    logic credit_err_r;
    logic overflow_s;

    assign overflow_s = credit_in & ~send_s & (credits_r == MAX_CREDITS);

    // Sticky overflow flag: a credit returned while the counter is already full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_err_r <= 1'b0;
        end else if (overflow_s) begin
            credit_err_r <= 1'b1;
        end else begin
            credit_err_r <= credit_err_r;
        end
    end

    assign credit_err = credit_err_r;
`else
    assign credit_err = 1'b0;
`endif

    assign axis_tready = tready_s;
    assign send_out    = send_s;
    assign is_tail_out = send_s & last_flit_s & last_r;
    assign data_out    = rst_n ? flit_s : {FLIT_WIDTH{1'b0}};
    assign dest_out    = rst_n ? dest_r : {TDEST_WIDTH{1'b0}};
    assign user_out    = rst_n ? user_r : {TUSER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_flit_serializer.sv
// Bench for axis_flit_serializer: queue-of-flits reference model checked every cycle,
// plus directed literal expectations for the key scenarios.
module tb_axis_flit_serializer;

    localparam int TDW   = 512;
    localparam int SF    = 4;
    localparam int FW    = TDW / SF;
    localparam int DW    = 6;
    localparam int UW    = 32;
    localparam int DEPTH = 4;
`ifdef AXIS_FLIT_SERIALIZER_CREDIT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           axis_tvalid = 1'b0;
    logic           axis_tready;
    logic [TDW-1:0] axis_tdata = '0;
    logic           axis_tlast = 1'b0;
    logic [UW-1:0]  axis_tuser = '0;
    logic [DW-1:0]  axis_tdest = '0;
    logic [FW-1:0]  data_out;
    logic [DW-1:0]  dest_out;
    logic [UW-1:0]  user_out;
    logic           is_tail_out;
    logic           send_out;
    logic           credit_in = 1'b0;
    logic           credit_err;

    always #5 clk = ~clk;

    axis_flit_serializer #(
        .TDEST_WIDTH(DW),
        .TDATA_WIDTH(TDW),
        .TUSER_WIDTH(UW),
        .SERIALIZATION_FACTOR(SF),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .axis_tdata(axis_tdata),
        .axis_tlast(axis_tlast),
        .axis_tuser(axis_tuser),
        .axis_tdest(axis_tdest),
        .data_out(data_out),
        .dest_out(dest_out),
        .user_out(user_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
        .credit_in(credit_in),
        .credit_err(credit_err)
    );

    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic [UW-1:0] user;
        logic          tail;
    } flit_t;

    flit_t pend[$];
    int    m_cred = DEPTH;
    bit    m_err = 1'b0;
    int    n_send = 0;
    int    errors = 0;
    int    checks = 0;

    logic          o_send, o_tready, o_tail, o_err;
    logic [FW-1:0] o_data;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        bit    exp_send, exp_tready, exp_tail, accept;
        flit_t f;
        @(negedge clk);
        o_send   = send_out;
        o_tready = axis_tready;
        o_tail   = is_tail_out;
        o_err    = credit_err;
        o_data   = data_out;
        chk("credit_err", FW'(credit_err), FW'(m_err));
        if (!rst_n) begin
            chk("rst_tready", FW'(axis_tready), '0);
            chk("rst_send", FW'(send_out), '0);
            chk("rst_tail", FW'(is_tail_out), '0);
            chk("rst_data", data_out, '0);
            chk("rst_dest", FW'(dest_out), '0);
            chk("rst_user", FW'(user_out), '0);
            pend.delete();
            m_cred = DEPTH;
            m_err  = 1'b0;
        end else begin
            exp_send   = (pend.size() > 0) && (m_cred > 0);
            exp_tready = (pend.size() == 0) || (exp_send && pend.size() == 1);
            exp_tail   = 1'b0;
            if (pend.size() > 0) begin
                exp_tail = exp_send && pend[0].tail;
                chk("m_data", data_out, pend[0].data);
                chk("m_dest", FW'(dest_out), FW'(pend[0].dest));
                chk("m_user", FW'(user_out), FW'(pend[0].user));
            end
            chk("m_send", FW'(send_out), FW'(exp_send));
            chk("m_tready", FW'(axis_tready), FW'(exp_tready));
            chk("m_tail", FW'(is_tail_out), FW'(exp_tail));
            accept = axis_tvalid && exp_tready;
            if (exp_send) begin
                n_send++;
                void'(pend.pop_front());
            end
            if (accept) begin
                for (int k = 0; k < SF; k++) begin
                    f.data = axis_tdata[k*FW +: FW];
                    f.dest = axis_tdest;
                    f.user = axis_tuser;
                    f.tail = axis_tlast && (k == SF - 1);
                    pend.push_back(f);
                end
            end
            if (exp_send && !credit_in) begin
                m_cred--;
            end else if (!exp_send && credit_in) begin
                if (m_cred == DEPTH) begin
                    if (ERR_EN) m_err = 1'b1;
                end else begin
                    m_cred++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [FW-1:0] base, input logic last,
                            input logic [DW-1:0] dest, input logic [UW-1:0] user);
        for (int k = 0; k < SF; k++) begin
            axis_tdata[k*FW +: FW] = base + FW'(k);
        end
        axis_tlast  = last;
        axis_tdest  = dest;
        axis_tuser  = user;
        axis_tvalid = 1'b1;
    endtask

    initial begin
        int base_cnt;
        repeat (2) @(posedge clk);
        #1;
        tick();
        chk("reset_tready", FW'(o_tready), FW'(0));
        chk("reset_send", FW'(o_send), FW'(0));
        rst_n = 1'b1;

        // Single beat, flits 0..3, tail only on the fourth; credits returned alongside.
        set_beat(128'h0, 1'b1, 6'h2A, 32'hCAFE_0001);
        tick();
        chk("t1_accept", FW'(o_tready), FW'(1));
        axis_tvalid = 1'b0;
        credit_in   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_send", FW'(o_send), FW'(1));
            chk("t1_data", o_data, FW'(k));
            chk("t1_tail", FW'(o_tail), FW'(k == 3));
        end
        credit_in = 1'b0;
        tick();
        chk("t1_idle_send", FW'(o_send), FW'(0));

        // Back-to-back beats with tvalid held: 8 flits, tready on flit 4 and 8.
        credit_in = 1'b1;
        set_beat(128'h10, 1'b0, 6'h05, 32'h0000_1111);
        tick();
        set_beat(128'h20, 1'b1, 6'h06, 32'h0000_2222);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("t2_send", FW'(o_send), FW'(1));
            chk("t2_tready", FW'(o_tready), FW'(c == 4 || c == 8));
            chk("t2_data", o_data, (c <= 4) ? FW'(16 + c - 1) : FW'(32 + c - 5));
            if (c == 4) axis_tvalid = 1'b0;
        end
        credit_in = 1'b0;

        // No credit return: four flits then stall; one credit releases the fifth.
        base_cnt = n_send;
        set_beat(128'h30, 1'b0, 6'h07, 32'h0000_3333);
        tick();
        set_beat(128'h40, 1'b1, 6'h08, 32'h0000_4444);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("t3_send", FW'(o_send), FW'(1));
        end
        axis_tvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_stall_send", FW'(o_send), FW'(0));
            chk("t3_stall_tready", FW'(o_tready), FW'(0));
            chk("t3_stall_data", o_data, FW'(64));
        end
        credit_in = 1'b1;
        tick();
        chk("t3_credit_cycle", FW'(o_send), FW'(0));
        credit_in = 1'b0;
        tick();
        chk("t3_fifth_send", FW'(o_send), FW'(1));
        chk("t3_fifth_data", o_data, FW'(64));
        chk("t3_count", FW'(n_send - base_cnt), FW'(5));
        tick();
        chk("t3_restall", FW'(o_send), FW'(0));

        // Send and credit in the same cycle at one credit: no stall.
        credit_in = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("t4_send", FW'(o_send), FW'(1));
            chk("t4_data", o_data, FW'(64 + c));
            chk("t4_tail", FW'(o_tail), FW'(c == 3));
        end

        // Refill to the maximum, then one extra credit.
        for (int c = 0; c < 4; c++) tick();
        credit_in = 1'b0;
        tick();
        chk("t5_credit_err", FW'(o_err), FW'(ERR_EN));
        set_beat(128'h50, 1'b0, 6'h09, 32'h0000_5555);
        tick();
        set_beat(128'h60, 1'b1, 6'h0A, 32'h0000_6666);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("t5_send", FW'(o_send), FW'(1));
        end
        axis_tvalid = 1'b0;
        tick();
        chk("t5_saturated", FW'(o_send), FW'(0));

        // Reset in the middle of a beat discards it.
        credit_in = 1'b1;
        tick();
        tick();
        chk("t6_flit0", o_data, FW'(96));
        tick();
        chk("t6_flit1", o_data, FW'(97));
        rst_n     = 1'b0;
        credit_in = 1'b0;
        tick();
        chk("t6_rst_send", FW'(o_send), FW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_tready", FW'(o_tready), FW'(1));
        chk("t6_no_residual", FW'(o_send), FW'(0));
        chk("t6_err_cleared", FW'(o_err), FW'(0));
        tick();
        chk("t6_no_residual2", FW'(o_send), FW'(0));
        set_beat(128'h70, 1'b1, 6'h0B, 32'h0000_7777);
        tick();
        axis_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_after_send", FW'(o_send), FW'(1));
            chk("t6_after_data", o_data, FW'(112 + k));
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
